// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt scheduler feeding CP0: synchronises hw interrupts, picks one exccode per cycle
// from MEM-stage flags and pending interrupts, and holds off new exceptions while CP0 updates.
module cp0_exc_ctrl #(
  parameter int HOLDOFF  = 2,
  parameter int SYNC_STG = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [5:0]  hw_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_exc_i,
  input  logic        stall_i,
  output logic [5:0]  int_o,
  output logic [4:0]  exccode_o,
  output logic        exc_taken_o,
  output logic        busy_o
);

  localparam int HC_W = $clog2(HOLDOFF) + 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLDOFF - 1);

  localparam logic [4:0] C_INT  = 5'h00;
  localparam logic [4:0] C_ADEL = 5'h04;
  localparam logic [4:0] C_ADES = 5'h05;
  localparam logic [4:0] C_SYS  = 5'h08;
  localparam logic [4:0] C_BP   = 5'h09;
  localparam logic [4:0] C_RI   = 5'h0a;
  localparam logic [4:0] C_OV   = 5'h0c;
  localparam logic [4:0] C_ERET = 5'h11;
  localparam logic [4:0] C_NONE = 5'h10;

  typedef enum logic {S_RUN, S_HOLD} state_e;

  state_e                       state_q, state_d;
  logic [HC_W-1:0]              hold_cnt_q, hold_cnt_d;
  logic [SYNC_STG-1:0][5:0]     sync_q, sync_d;

  logic       int_req;
  logic       cand_vld;
  logic [4:0] cand_code;
  logic       accept;

  // Only the IE/EXL/IM fields of Status and the software IP bits of Cause matter here.
  logic unused_ok;
  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

  assign int_o   = sync_q[SYNC_STG-1];
  assign int_req = status_i[0] & ~status_i[1] & (|({int_o, cause_i[9:8]} & status_i[15:8]));

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], hw_int_i};
  end

  // A bubble carries neither an instruction exception nor an interrupt slot.
  always_comb begin
    cand_vld  = 1'b0;
    cand_code = C_NONE;
    if (mem_valid_i) begin
      cand_vld = 1'b1;
      if      (int_req)      cand_code = C_INT;
      else if (mem_exc_i[0]) cand_code = C_ADEL;
      else if (mem_exc_i[1]) cand_code = C_RI;
      else if (mem_exc_i[2]) cand_code = C_OV;
      else if (mem_exc_i[3]) cand_code = C_SYS;
      else if (mem_exc_i[4]) cand_code = C_BP;
      else if (mem_exc_i[5]) cand_code = C_ADEL;
      else if (mem_exc_i[6]) cand_code = C_ADES;
      else if (mem_exc_i[7]) cand_code = C_ERET;
      else                   cand_vld  = 1'b0;
    end
  end

  // Handshake: the candidate is offered (cand_vld) and accepted only when ready
  // (RUN and not stalled); nothing is latched, so a refused candidate is simply re-offered.
  assign accept      = (state_q == S_RUN) & ~stall_i & cand_vld;
  assign exccode_o   = accept ? cand_code : C_NONE;
  assign exc_taken_o = accept;
  assign busy_o      = (state_q == S_HOLD);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          if (hold_cnt_q == '0) state_d = S_RUN;
          else                  hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= S_RUN;
      hold_cnt_q <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sync_q     <= sync_d;
    end
  end

endmodule
